// File: rtl/inst_fetch_arbiter_if.sv
// Bundle between the two fetch ways, the instruction memory port and the
// inst_fetch_arbiter. The arbiter uses the slave modport; the fetch/memory side uses master.
`timescale 1ns/1ps
interface inst_fetch_arbiter_if;
  logic        way0_request_i;
  logic [31:0] way0_addr_i;
  logic        way1_request_i;
  logic [31:0] way1_addr_i;
  logic        jumpFlag_i;
  logic        mem_ready_i;
  logic        mem_dataOk_i;
  logic [31:0] mem_data_i;
  logic        mem_request_o;
  logic [31:0] mem_addr_o;
  logic        way0_dataOk_o;
  logic        way1_dataOk_o;
  logic [31:0] way0_inst_o;
  logic [31:0] way1_inst_o;
  logic        busy_o;
  logic        timeout_o;

  modport slave (
    input  way0_request_i, way0_addr_i, way1_request_i, way1_addr_i,
    input  jumpFlag_i, mem_ready_i, mem_dataOk_i, mem_data_i,
    output mem_request_o, mem_addr_o, way0_dataOk_o, way1_dataOk_o,
    output way0_inst_o, way1_inst_o, busy_o, timeout_o
  );

  modport master (
    output way0_request_i, way0_addr_i, way1_request_i, way1_addr_i,
    output jumpFlag_i, mem_ready_i, mem_dataOk_i, mem_data_i,
    input  mem_request_o, mem_addr_o, way0_dataOk_o, way1_dataOk_o,
    input  way0_inst_o, way1_inst_o, busy_o, timeout_o
  );
endinterface

// File: rtl/inst_fetch_arbiter.sv
// Two-way instruction fetch arbiter: grants one way at a time onto a single
// memory port, with round-robin ties, redirect kill and a wait-cycle timeout.
`timescale 1ns/1ps
module inst_fetch_arbiter #(
  parameter int TimeoutCycles = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  inst_fetch_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TimeoutCycles);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant_way;
  logic        grant_fire;
  logic        timeout_hit;
  logic        clr_cnt;
  logic        inc_cnt;
  logic [15:0] wait_cnt;
  logic [15:0] cnt_inc;
  logic        mem_request_q;
  logic [31:0] mem_addr_q;
  logic        timeout_q;
  logic        deliver;
  logic        way0_ok;
  logic        way1_ok;
  logic        busy;
  logic        any_req;

  assign any_req = bus.way0_request_i | bus.way1_request_i;
  // A lone requester wins outright; on a tie the way not granted last time wins.
  assign grant_way = (bus.way0_request_i & bus.way1_request_i) ? ~last_grant
                                                               : bus.way1_request_i;
  assign cnt_inc = wait_cnt + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_fire  = 1'b0;
    timeout_hit = 1'b0;
    clr_cnt     = 1'b0;
    inc_cnt     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !bus.jumpFlag_i) begin
          state_nxt  = REQ;
          grant_fire = 1'b1;
        end
      end
      REQ: begin
        // A redirect withdraws the request even if memory accepted it this cycle.
        if (bus.jumpFlag_i) begin
          state_nxt = IDLE;
        end else if (bus.mem_ready_i) begin
          state_nxt = WAIT;
          clr_cnt   = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mem_dataOk_i) begin
          state_nxt = IDLE;
        end else if (bus.jumpFlag_i) begin
          state_nxt = DROP;
          clr_cnt   = 1'b1;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      DROP: begin
        if (bus.mem_dataOk_i) begin
          state_nxt = IDLE;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    deliver = (state == WAIT) && bus.mem_dataOk_i && !bus.jumpFlag_i;
    way0_ok = deliver && !last_grant;
    way1_ok = deliver && last_grant;
  end

  // last_grant doubles as the owner of the outstanding transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_request_q <= 1'b0;
      mem_addr_q    <= 32'h0;
      last_grant    <= 1'b1;
      wait_cnt      <= 16'h0;
      timeout_q     <= 1'b0;
    end else begin
      mem_request_q <= (state_nxt == REQ);
      timeout_q     <= timeout_hit;
      if (grant_fire) begin
        mem_addr_q <= grant_way ? bus.way1_addr_i : bus.way0_addr_i;
        last_grant <= grant_way;
      end
      if (clr_cnt) begin
        wait_cnt <= 16'h0;
      end else if (inc_cnt) begin
        wait_cnt <= cnt_inc;
      end
    end
  end

  assign bus.mem_request_o = mem_request_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.way0_dataOk_o = way0_ok;
  assign bus.way1_dataOk_o = way1_ok;
  assign bus.way0_inst_o   = bus.mem_data_i;
  assign bus.way1_inst_o   = bus.mem_data_i;
  assign bus.busy_o        = busy;
  assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Scoreboard bench for inst_fetch_arbiter: a transaction-level model predicts
// every cycle's outputs into a queue, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_inst_fetch_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  inst_fetch_arbiter_if bus();

  inst_fetch_arbiter #(.TimeoutCycles(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        d0;
    logic        d1;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        busy;
    logic        to;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Model of the single outstanding fetch, kept as transaction facts.
  bit          m_live;
  bit          m_accepted;
  bit          m_killed;
  int          m_way;
  int          m_waited;
  bit          m_last_was_1;
  logic [31:0] m_addr;
  bit          m_to;

  task automatic model_reset();
    m_live = 0; m_accepted = 0; m_killed = 0; m_way = 0; m_waited = 0;
    m_last_was_1 = 1; m_addr = 32'h0; m_to = 0;
  endtask

  task automatic expect_eq(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive(bit r0, logic [31:0] a0, bit r1, logic [31:0] a1,
                       bit jmp, bit rdy, bit dok, logic [31:0] dat);
    obs_t e;
    @(posedge clk);
    #1;
    bus.way0_request_i = r0;  bus.way0_addr_i = a0;
    bus.way1_request_i = r1;  bus.way1_addr_i = a1;
    bus.jumpFlag_i = jmp;     bus.mem_ready_i = rdy;
    bus.mem_dataOk_i = dok;   bus.mem_data_i = dat;
    e.req  = m_live && !m_accepted && !m_killed;
    e.addr = m_addr;
    e.d0   = m_live && m_accepted && dok && !jmp && (m_way == 0);
    e.d1   = m_live && m_accepted && dok && !jmp && (m_way == 1);
    e.i0   = dat;
    e.i1   = dat;
    e.busy = m_live;
    e.to   = m_to;
    exp_q.push_back(e);
    m_to = 0;
    if (!m_live) begin
      if ((r0 || r1) && !jmp) begin
        if (r0 && r1) m_way = m_last_was_1 ? 0 : 1;
        else          m_way = r0 ? 0 : 1;
        m_last_was_1 = (m_way == 1);
        m_addr = (m_way == 0) ? a0 : a1;
        m_live = 1; m_accepted = 0; m_killed = 0;
      end
    end else if (!m_accepted && !m_killed) begin
      if (jmp) m_live = 0;
      else if (rdy) begin m_accepted = 1; m_waited = 0; end
    end else begin
      if (dok) m_live = 0;
      else if (m_accepted && jmp) begin m_accepted = 0; m_killed = 1; m_waited = 0; end
      else begin
        m_waited++;
        if (m_waited == TO) begin m_live = 0; m_to = 1; end
      end
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(0, 32'h0, 0, 32'h0, 0, 0, 0, $urandom);
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{bus.mem_request_o, bus.mem_addr_o, bus.way0_dataOk_o, bus.way1_dataOk_o,
            bus.way0_inst_o, bus.way1_inst_o, bus.busy_o, bus.timeout_o};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL outputs cycle %0d: got req=%b addr=%h ok0=%b ok1=%b i0=%h i1=%h busy=%b to=%b want req=%b addr=%h ok0=%b ok1=%b i0=%h i1=%h busy=%b to=%b",
                    cyc, a.req, a.addr, a.d0, a.d1, a.i0, a.i1, a.busy, a.to,
                    e.req, e.addr, e.d0, e.d1, e.i0, e.i1, e.busy, e.to);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.way0_request_i = 0; bus.way0_addr_i = 0; bus.way1_request_i = 0; bus.way1_addr_i = 0;
    bus.jumpFlag_i = 0; bus.mem_ready_i = 0; bus.mem_dataOk_i = 0; bus.mem_data_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    expect_eq("reset_state", {bus.mem_request_o, bus.mem_addr_o, bus.way0_dataOk_o,
              bus.way1_dataOk_o, bus.busy_o, bus.timeout_o}, 64'h0);
    @(posedge clk); #1 reset_n = 1;

    // Tie after reset: way0 then way1, immediate ready/data.
    for (int k = 0; k < 6; k++)
      drive(1, 32'h0000_1000, 1, 32'h0000_1004, 0, 1, 1, 32'h1111_0000 + k);
    idle(2);

    // way1 alone with memory stalling four cycles.
    drive(0, 32'h0, 1, 32'h0000_2000, 0, 0, 0, 32'h0);
    for (int k = 0; k < 4; k++) drive(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h5);
    drive(0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h6);
    drive(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h7);
    idle(1);

    // Redirect in WAIT, late data dropped, then a normal grant.
    drive(1, 32'h0000_3000, 0, 32'h0, 0, 0, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF);
    drive(0, 32'h0, 1, 32'h0000_3004, 0, 1, 1, 32'h8);
    drive(0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h9);
    drive(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'hA);
    idle(1);

    // Redirect coinciding with data in WAIT.
    drive(1, 32'h0000_4000, 0, 32'h0, 0, 1, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 1, 0, 1, 32'hB);
    idle(1);

    // Timeout after TO silent WAIT cycles; later data ignored.
    drive(0, 32'h0, 1, 32'h0000_5000, 0, 1, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0);
    idle(TO + 1);
    for (int k = 0; k < 2; k++) drive(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'hC);

    // Reset asserted while way1 waits for data.
    drive(0, 32'h0, 1, 32'h0000_6000, 0, 1, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0);
    drive(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1 bus.mem_dataOk_i = 1; bus.mem_data_i = 32'h1234_5678;
    #1 expect_eq("deliver_before_reset", {bus.way0_dataOk_o, bus.way1_dataOk_o}, 64'h1);
    reset_n = 0;
    #1 expect_eq("async_reset_outputs", {bus.mem_request_o, bus.mem_addr_o, bus.way0_dataOk_o,
                 bus.way1_dataOk_o, bus.busy_o, bus.timeout_o}, 64'h0);
    bus.mem_dataOk_i = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    model_reset();
    for (int k = 0; k < 3; k++) drive(0, 32'h0, 0, 32'h0, 0, 1, 1, 32'hE);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 9) < 5, $urandom, $urandom_range(0, 9) < 5, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 5,
            $urandom_range(0, 9) < 3, $urandom);
    idle(TO + 2);

    @(negedge clk);
    #1 expect_eq("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_arbiter.md
INST_FETCH_ARBITER -- requirements
Module: inst_fetch_arbiter

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 255, WAIT/DROP cycles without mem_dataOk_i before abort (legal 1..65535).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; reset_n input 1, asynchronous active-low reset.
REQ-003 way0_request_i  input  1   way0 fetch request.
REQ-004 way0_addr_i  input  32   way0 fetch address.
REQ-005 way1_request_i  input  1   way1 fetch request.
REQ-006 way1_addr_i  input  32   way1 fetch address.
REQ-007 jumpFlag_i  input  1   redirect; kills pending/outstanding fetch.
REQ-008 mem_ready_i  input  1   memory accepts mem_request_o this cycle.
REQ-009 mem_dataOk_i  input  1   memory returns data this cycle.
REQ-010 mem_data_i  input  32   returned instruction.
REQ-011 mem_request_o  output  1   registered memory request.
REQ-012 mem_addr_o  output  32   registered address of granted way.
REQ-013 way0_dataOk_o / way1_dataOk_o  output  1 each   data-valid to owning way.
REQ-014 way0_inst_o / way1_inst_o  output  32 each   mem_data_i passthrough.
REQ-015 busy_o  output  1   high when state != IDLE.
REQ-016 timeout_o  output  1   one-cycle pulse on abort.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DROP; one transaction outstanding max.
REQ-018 IDLE: any request and !jumpFlag_i -> grant, latch address into mem_addr_o, set mem_request_o, go REQ next cycle; jumpFlag_i high -> no grant, stay IDLE.
REQ-019 Grant: single requester wins; both requesting -> way opposite last_grant wins; last_grant updated at grant.
REQ-020 REQ: mem_request_o=1, mem_addr_o stable; mem_ready_i=1 and !jumpFlag_i -> WAIT, mem_request_o cleared next cycle.
REQ-021 REQ with jumpFlag_i=1 (regardless of mem_ready_i) -> IDLE, mem_request_o cleared, request treated as never accepted.
REQ-022 WAIT: mem_dataOk_i=1 and !jumpFlag_i -> granted way's dataOk_o=1 same cycle (combinational), -> IDLE.
REQ-023 WAIT: jumpFlag_i=1 with mem_dataOk_i=1 -> no dataOk_o, -> IDLE; jumpFlag_i=1 without mem_dataOk_i -> DROP.
REQ-024 DROP: mem_dataOk_i consumed with no dataOk_o, -> IDLE; jumpFlag_i in DROP ignored.
REQ-025 wayX_dataOk_o SHALL never both be high; never high outside WAIT.
REQ-026 way0_inst_o and way1_inst_o SHALL both equal mem_data_i every cycle.
REQ-027 16-bit wait counter SHALL clear on entering WAIT/DROP, increment each WAIT/DROP cycle without mem_dataOk_i; reaching TimeoutCycles -> IDLE, timeout_o pulse one cycle, no dataOk_o.
REQ-028 Minimum grant-to-grant spacing SHALL be 3 cycles (IDLE, REQ, WAIT with immediate ready/dataOk).
REQ-029 mem_dataOk_i in IDLE or REQ SHALL be ignored.

Reset
REQ-030 reset_n low SHALL asynchronously force: state IDLE, mem_request_o 0, mem_addr_o 0, last_grant way1 (way0 wins first tie), counter 0, timeout_o 0, busy_o 0, both dataOk_o 0.
REQ-031 Reset mid-transaction SHALL abandon it; a late mem_dataOk_i after reset release SHALL be ignored (IDLE).

Verification
REQ-032 Both request after reset, addr0=0x0000_1000, addr1=0x0000_1004, ready/dataOk immediate -> grants way0 then way1; mem_addr_o 0x1000 then 0x1004; way0_dataOk_o then way1_dataOk_o, 3 cycles apart.
REQ-033 way1 alone, mem_ready_i held low 4 cycles -> mem_request_o high 5 cycles, mem_addr_o stable, busy_o high.
REQ-034 jumpFlag_i in WAIT, mem_dataOk_i 2 cycles later with 0xDEAD_BEEF -> DROP, no dataOk_o, IDLE after; next request granted normally.
REQ-035 jumpFlag_i same cycle as mem_dataOk_i in WAIT -> no dataOk_o, IDLE next cycle.
REQ-036 TimeoutCycles=4, no mem_dataOk_i after accept -> timeout_o pulse after 4 WAIT cycles, IDLE; later mem_dataOk_i ignored.
REQ-037 reset_n low during WAIT -> all outputs 0 immediately; post-release stray mem_dataOk_i produces no dataOk_o.
